// File: rtl/bin_sched_pkg.sv
// Shared state encoding and default geometry for the binary inter-block scheduler.
package bin_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    OUTPUT
  } state_t;

  localparam int DEF_SEQ_LEN    = 30;
  localparam int DEF_NUM_BLOCKS = 4;
  localparam int DEF_IN_W       = 16;
  localparam int DEF_OUT_W      = 64;
  localparam int WD_LIMIT       = 16;

endpackage

// File: rtl/bin_sched_collect.sv
// Assembles per-block datapath results into one wide row result, slice idx at a time.
module bin_sched_collect
  import bin_sched_pkg::*;
#(
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [1:0]                  idx,
  input  logic [OUT_W-1:0]            din,
  output logic [NUM_BLOCKS*OUT_W-1:0] res_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (clear) begin
      res_data <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (idx == 2'(i)) res_data[i*OUT_W +: OUT_W] <= din;
      end
    end
  end

endmodule

// File: rtl/bin_inter_scheduler.sv
// Row-by-block scheduler: fetch a binary row, issue it once per weight block, collect results.
// Optional BIN_SCHED_WATCHDOG_EN adds wd_err and a 16-cycle timeout on WAIT.
module bin_inter_scheduler
  import bin_sched_pkg::*;
#(
  parameter int SEQ_LEN    = DEF_SEQ_LEN,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic                        in_rd_en,
  output logic [4:0]                  in_rd_addr,
  input  logic [IN_W-1:0]             in_rd_data,
  output logic [IN_W-1:0]             dp_data_in,
  output logic                        dp_data_in_valid,
  output logic [1:0]                  dp_block_sel,
  input  logic [OUT_W-1:0]            dp_data_out,
  input  logic                        dp_data_out_valid,
  output logic [NUM_BLOCKS*OUT_W-1:0] res_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        busy,
  output logic                        done
`ifdef BIN_SCHED_WATCHDOG_EN
  , output logic                      wd_err
`endif
);

  localparam logic [4:0] T_LAST = 5'(SEQ_LEN - 1);
  localparam logic [1:0] B_LAST = 2'(NUM_BLOCKS - 1);

  state_t     state;
  logic [4:0] t;
  logic [1:0] b;
`ifdef BIN_SCHED_WATCHDOG_EN
  logic [3:0] wd_cnt;
`endif

  assign busy = (state != IDLE);

  // dp_data_in doubles as the row holding register; all strobes are one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      t                <= '0;
      b                <= '0;
      in_rd_en         <= 1'b0;
      in_rd_addr       <= '0;
      dp_data_in       <= '0;
      dp_data_in_valid <= 1'b0;
      dp_block_sel     <= '0;
      res_valid        <= 1'b0;
      done             <= 1'b0;
`ifdef BIN_SCHED_WATCHDOG_EN
      wd_cnt           <= '0;
      wd_err           <= 1'b0;
`endif
    end else begin
      in_rd_en         <= 1'b0;
      dp_data_in_valid <= 1'b0;
      done             <= 1'b0;
`ifdef BIN_SCHED_WATCHDOG_EN
      wd_err           <= 1'b0;
`endif
      if (abort) begin
        state     <= IDLE;
        t         <= '0;
        b         <= '0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              t          <= '0;
              b          <= '0;
              in_rd_en   <= 1'b1;
              in_rd_addr <= '0;
              state      <= FETCH;
            end
          end
          FETCH: begin
            dp_data_in       <= in_rd_data;
            dp_data_in_valid <= 1'b1;
            dp_block_sel     <= b;
            state            <= ISSUE;
          end
          ISSUE: begin
`ifdef BIN_SCHED_WATCHDOG_EN
            wd_cnt <= '0;
`endif
            state  <= WAIT;
          end
          WAIT: begin
            if (dp_data_out_valid) begin
              if (b < B_LAST) begin
                b                <= b + 2'd1;
                dp_data_in_valid <= 1'b1;
                dp_block_sel     <= b + 2'd1;
                state            <= ISSUE;
              end else begin
                res_valid <= 1'b1;
                state     <= OUTPUT;
              end
            end
`ifdef BIN_SCHED_WATCHDOG_EN
            else if (wd_cnt == 4'(WD_LIMIT - 1)) begin
              wd_err <= 1'b1;
              t      <= '0;
              b      <= '0;
              state  <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + 4'd1;
            end
`endif
          end
          OUTPUT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (t < T_LAST) begin
                t          <= t + 5'd1;
                b          <= '0;
                in_rd_en   <= 1'b1;
                in_rd_addr <= t + 5'd1;
                state      <= FETCH;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  bin_sched_collect #(
    .NUM_BLOCKS(NUM_BLOCKS),
    .OUT_W     (OUT_W)
  ) u_collect (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state == IDLE) && start && !abort),
    .wr_en   ((state == WAIT) && dp_data_out_valid && !abort),
    .idx     (b),
    .din     (dp_data_out),
    .res_data(res_data)
  );

endmodule

// File: doc/bin_inter_scheduler.md
BIN_INTER_SCHEDULER -- requirements
Module: bin_inter_scheduler

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 30, meaning time steps (input rows) per run.
REQ-002 SHALL have parameter NUM_BLOCKS, default 4, meaning weight blocks per time step (block_sel range).
REQ-003 SHALL have parameter IN_W, default 16, meaning binary input row width.
REQ-004 SHALL have parameter OUT_W, default 64, meaning datapath result bits per block.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle run request.
REQ-008 SHALL have port abort  input  1  synchronous run cancel.
REQ-009 SHALL have port in_rd_en  output  1  input-buffer read strobe.
REQ-010 SHALL have port in_rd_addr  output  5  input-buffer row address.
REQ-011 SHALL have port in_rd_data  input  IN_W  input-buffer data, valid one cycle after in_rd_en.
REQ-012 SHALL have port dp_data_in  output  IN_W  row to datapath.
REQ-013 SHALL have port dp_data_in_valid  output  1  datapath issue strobe.
REQ-014 SHALL have port dp_block_sel  output  2  weight block select.
REQ-015 SHALL have port dp_data_out  input  OUT_W  datapath result.
REQ-016 SHALL have port dp_data_out_valid  input  1  datapath result strobe.
REQ-017 SHALL have port res_data  output  NUM_BLOCKS*OUT_W  assembled row result, block b in bits [b*OUT_W +: OUT_W].
REQ-018 SHALL have ports res_valid output 1 and res_ready input 1, valid/ready handshake on res_data.
REQ-019 SHALL have ports busy output 1 (state not IDLE) and done output 1 (one-cycle run-complete pulse).

Function
REQ-020 SHALL implement states IDLE, FETCH, ISSUE, WAIT, OUTPUT.
REQ-021 IDLE: on start (abort low) clear t=0, b=0, go FETCH; start in any other state SHALL be ignored.
REQ-022 FETCH: in_rd_en=1, in_rd_addr=t for exactly one cycle, go ISSUE; in_rd_data SHALL be registered into a row holding register on the following edge.
REQ-023 ISSUE: dp_data_in_valid=1 for exactly one cycle with dp_data_in=held row, dp_block_sel=b, go WAIT.
REQ-024 WAIT: on dp_data_out_valid capture dp_data_out into res_data slice b; if b<NUM_BLOCKS-1 then b++ and go ISSUE, else go OUTPUT; dp_data_out_valid outside WAIT SHALL be ignored.
REQ-025 OUTPUT: res_valid=1, res_data stable until res_ready sampled high; on handshake, if t<SEQ_LEN-1 then t++, b=0, go FETCH, else pulse done one cycle and go IDLE.
REQ-026 Minimum per-row latency SHALL be 2+2*NUM_BLOCKS cycles plus res_ready wait (datapath responds one cycle after issue).
REQ-027 dp_data_in_valid SHALL never be high in two consecutive cycles; at most one datapath request outstanding.
REQ-028 abort in any non-IDLE state SHALL force IDLE on the next edge, deassert res_valid, clear counters, no done; abort with start in IDLE: abort wins.
REQ-029 t and b SHALL never wrap; t stays below SEQ_LEN, b below NUM_BLOCKS.
REQ-030 dp_block_sel, in_rd_addr, dp_data_in SHALL hold last value when not strobed.

Reset
REQ-031 rst_n low SHALL asynchronously set IDLE, t=0, b=0, all outputs 0 (res_data, dp_data_in, in_rd_addr, dp_block_sel included), mid-run included.

Configuration
REQ-032 With BIN_SCHED_WATCHDOG_EN defined, an extra output wd_err (1 bit) SHALL pulse and the FSM SHALL return to IDLE (no done) if WAIT persists 16 cycles; without it WAIT SHALL wait indefinitely and wd_err SHALL not exist.

Structure
REQ-033 Package bin_sched_pkg SHALL hold the state enum and default SEQ_LEN/NUM_BLOCKS/IN_W/OUT_W constants.
REQ-034 Sub-module bin_sched_collect SHALL implement slice capture into res_data (write enable, index b, clear).

Verification
REQ-035 start, dp responds 1 cycle after each issue with 0x...0+b, res_ready=1 -> 30 res_valid rows, each slices 0..3 = block index, done once after row 29.
REQ-036 dp response delayed 5 cycles on block 2 -> no reissue, dp_data_in_valid pulses exactly 4 per row, sel order 0,1,2,3.
REQ-037 res_ready held low 10 cycles on row 3 -> res_valid and res_data stable, no in_rd_en until accept.
REQ-038 abort during WAIT of row 7 -> IDLE next cycle, res_valid 0, no done; subsequent start restarts at in_rd_addr=0.
REQ-039 start while busy and stray dp_data_out_valid in ISSUE -> no effect on counters or res_data.
REQ-040 rst_n low mid-row, BIN_SCHED_WATCHDOG_EN defined and dp silent -> outputs 0 on reset; watchdog case wd_err pulse after 16 WAIT cycles, IDLE, done 0.
